// File: rtl/loader_pkg.sv
// Shared types and widths for the byte-stream program loader.
package loader_pkg;

   localparam int unsigned LOADER_ADDR_W = 4;
   localparam int unsigned LOADER_DATA_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      HEADER,
      DATA,
      WRITE,
      CHECK,
      RUN,
      ERR
   } loader_state_t;

endpackage : loader_pkg

// File: rtl/loader_checksum.sv
// Wrap-around checksum accumulator for the loader frame.
// is_zero looks ahead: it flags whether acc + din would wrap to zero, so the
// checksum byte can be judged in the same cycle it is transferred.
module loader_checksum
   import loader_pkg::*;
#(
   parameter int unsigned W = LOADER_DATA_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         add_en,
   input  logic [W-1:0] din,
   output logic         is_zero
);

   logic [W-1:0] acc;
   logic [W-1:0] sum_c;

   // Carry out of the top bit is discarded.
   assign sum_c   = acc + din;
   assign is_zero = (sum_c == '0);

   // Accumulator: clear has priority over add.
   always_ff @(posedge clk) begin
      if (reset || clr) begin
         acc <= '0;
      end else if (add_en) begin
         acc <= sum_c;
      end
   end

endmodule : loader_checksum

// File: rtl/program_loader.sv
// Boot loader: receives header / data / checksum bytes, writes the data into
// program RAM and holds the CPU in reset until the checksum verifies.
module program_loader
   import loader_pkg::*;
#(
   parameter int unsigned ADDR_W    = LOADER_ADDR_W,
   parameter int unsigned DATA_W    = LOADER_DATA_W,
   parameter int unsigned WR_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              byte_valid,
   input  logic [DATA_W-1:0] byte_data,
   output logic              byte_ready,
   output logic              input_mode,
   output logic [ADDR_W-1:0] input_address,
   output logic [DATA_W-1:0] input_program,
   output logic              cpu_reset_n,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   words_loaded
);

   localparam int unsigned CNT_W  = ADDR_W + 1;
   localparam int unsigned HOLD_W = $clog2(WR_CYCLES) + 1;

   loader_state_t     state;
   logic [ADDR_W-1:0] addr;
   logic [CNT_W-1:0]  n_words;
   logic [HOLD_W-1:0] hold_cnt;

   logic              xfer_c;
   logic              start_ok_c;
   logic              ck_add_c;
   logic              ck_zero_c;
   logic [CNT_W-1:0]  words_next_c;

   // Handshake and start qualification; start only acts when no load is running.
   assign xfer_c       = byte_valid & byte_ready;
   assign start_ok_c   = start & ((state == IDLE) || (state == RUN) || (state == ERR));
   assign ck_add_c     = xfer_c & ((state == HEADER) || (state == DATA));
   assign words_next_c = words_loaded + CNT_W'(1);

   loader_checksum #(
      .W (DATA_W)
   ) u_checksum (
      .clk     (clk),
      .reset   (reset),
      .clr     (start_ok_c),
      .add_en  (ck_add_c),
      .din     (byte_data),
      .is_zero (ck_zero_c)
   );

   // Loader FSM with registered outputs; outputs change on the transition edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         addr          <= '0;
         n_words       <= '0;
         hold_cnt      <= '0;
         byte_ready    <= 1'b0;
         input_mode    <= 1'b0;
         input_address <= '0;
         input_program <= '0;
         cpu_reset_n   <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         error         <= 1'b0;
         words_loaded  <= '0;
      end else begin
         case (state)
            IDLE, RUN, ERR: begin
               if (start) begin
                  state        <= HEADER;
                  byte_ready   <= 1'b1;
                  busy         <= 1'b1;
                  done         <= 1'b0;
                  error        <= 1'b0;
                  cpu_reset_n  <= 1'b0;
                  words_loaded <= '0;
               end
            end

            HEADER: begin
               if (xfer_c) begin
                  n_words <= CNT_W'(byte_data[2*ADDR_W-1:ADDR_W]) + CNT_W'(1);
                  addr    <= byte_data[ADDR_W-1:0];
                  state   <= DATA;
               end
            end

            DATA: begin
               if (xfer_c) begin
                  input_address <= addr;
                  input_program <= byte_data;
                  input_mode    <= 1'b1;
                  byte_ready    <= 1'b0;
                  hold_cnt      <= '0;
                  state         <= WRITE;
               end
            end

            WRITE: begin
               if (hold_cnt == HOLD_W'(WR_CYCLES - 1)) begin
                  input_mode   <= 1'b0;
                  words_loaded <= words_next_c;
                  addr         <= addr + ADDR_W'(1);
                  byte_ready   <= 1'b1;
                  state        <= (words_next_c < n_words) ? DATA : CHECK;
               end else begin
                  hold_cnt <= hold_cnt + HOLD_W'(1);
               end
            end

            CHECK: begin
               if (xfer_c) begin
                  byte_ready <= 1'b0;
                  busy       <= 1'b0;
                  if (ck_zero_c) begin
                     state       <= RUN;
                     done        <= 1'b1;
                     cpu_reset_n <= 1'b1;
                  end else begin
                     state <= ERR;
                     error <= 1'b1;
                  end
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule : program_loader

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a table of frames plus hand-written
// sequences for restart, same-cycle start/valid and reset mid-load.
module tb_program_loader;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       byte_valid = 1'b0;
   logic [7:0] byte_data = 8'h00;
   logic       byte_ready;
   logic       input_mode;
   logic [3:0] input_address;
   logic [7:0] input_program;
   logic       cpu_reset_n;
   logic       busy;
   logic       done;
   logic       error;
   logic [4:0] words_loaded;

   program_loader #(
      .ADDR_W    (4),
      .DATA_W    (8),
      .WR_CYCLES (2)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .byte_valid    (byte_valid),
      .byte_data     (byte_data),
      .byte_ready    (byte_ready),
      .input_mode    (input_mode),
      .input_address (input_address),
      .input_program (input_program),
      .cpu_reset_n   (cpu_reset_n),
      .busy          (busy),
      .done          (done),
      .error         (error),
      .words_loaded  (words_loaded)
   );

   always #5 clk = ~clk;

   // Frame record: stream bytes, drive mode, expected outcome and RAM writes in order.
   typedef struct packed {
      logic [7:0]        nbytes;
      logic [0:19][7:0]  frame;
      logic              keep;
      logic              exp_done;
      logic [4:0]        exp_words;
      logic [0:15][3:0]  eaddr;
      logic [0:15][7:0]  edata;
   } vec_t;

   vec_t vecs [6];

   int checks = 0;
   int passed = 0;

   // RAM-side monitor: one log entry per write burst, plus protocol counters.
   logic [3:0] log_addr [256];
   logic [7:0] log_data [256];
   int         log_cnt     = 0;
   int         mode_cycles = 0;
   int         run_len     = 0;
   int         bad_run     = 0;
   int         unstable    = 0;
   int         rdy_viol    = 0;
   logic       prev_mode   = 1'b0;
   logic [3:0] held_addr   = 4'h0;
   logic [7:0] held_data   = 8'h00;

   always @(posedge clk) begin
      if (input_mode) begin
         mode_cycles <= mode_cycles + 1;
         run_len     <= run_len + 1;
         if (!prev_mode) begin
            log_addr[8'(log_cnt)] <= input_address;
            log_data[8'(log_cnt)] <= input_program;
            log_cnt               <= log_cnt + 1;
         end else if (input_address != held_addr || input_program != held_data) begin
            unstable <= unstable + 1;
         end
         held_addr <= input_address;
         held_data <= input_program;
      end else begin
         if (prev_mode && run_len != 2) bad_run <= bad_run + 1;
         run_len <= 0;
      end
      prev_mode <= input_mode;
   end

   always @(negedge clk) begin
      if (input_mode && byte_ready) rdy_viol <= rdy_viol + 1;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Present one byte and hold it until a transfer edge; optionally keep valid high afterwards.
   task automatic send_byte(input logic [7:0] b, input bit keep);
      bit got;
      got        = 1'b0;
      byte_data  = b;
      byte_valid = 1'b1;
      for (int k = 0; k < 64 && !got; k++) begin
         @(negedge clk);
         if (byte_ready) begin
            @(posedge clk);
            #1;
            got = 1'b1;
         end
      end
      if (!keep) byte_valid = 1'b0;
      if (!got) begin
         checks++;
         $display("FAIL send_byte_timeout: byte 0x%0h never accepted, expected acceptance", b);
      end
   endtask

   task automatic run_frame(input int vi, input bit do_start);
      vec_t v;
      int   base_log;
      int   base_mc;
      int   idx;
      v = vecs[vi];
      if (do_start) begin
         pulse_start();
         chk($sformatf("v%0d_start_flags", vi), 32'({busy, done, error, cpu_reset_n, byte_ready}), 32'h11);
         chk($sformatf("v%0d_start_words", vi), 32'(words_loaded), 32'h0);
      end
      base_log = log_cnt;
      base_mc  = mode_cycles;
      for (int k = 0; k < int'(v.nbytes); k++) send_byte(v.frame[5'(k)], v.keep);
      // Bytes offered after the frame must be ignored.
      byte_valid = 1'b1;
      byte_data  = 8'hFF;
      repeat (3) @(posedge clk);
      #1;
      byte_valid = 1'b0;
      chk($sformatf("v%0d_result", vi), 32'({done, error, cpu_reset_n, busy}),
          v.exp_done ? 32'hA : 32'h4);
      chk($sformatf("v%0d_words", vi), 32'(words_loaded), 32'(v.exp_words));
      chk($sformatf("v%0d_write_count", vi), 32'(log_cnt - base_log), 32'(v.exp_words));
      chk($sformatf("v%0d_mode_cycles", vi), 32'(mode_cycles - base_mc), 32'(2 * int'(v.exp_words)));
      for (int k = 0; k < int'(v.exp_words); k++) begin
         idx = base_log + k;
         chk($sformatf("v%0d_write%0d", vi, k), 32'({log_addr[8'(idx)], log_data[8'(idx)]}),
             32'({v.eaddr[4'(k)], v.edata[4'(k)]}));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] tail [5];
      int         base;

      // Table: valid frame, bad checksum, wrap, backpressure, single word, full 16 words.
      for (int i = 0; i < 6; i++) vecs[i] = '0;
      vecs[0].nbytes = 8'd7;
      vecs[0].frame  = {8'h40, 8'h79, 8'h30, 8'h7A, 8'h10, 8'h40, 8'h4D, 104'h0};
      vecs[0].keep   = 1'b0;  vecs[0].exp_done = 1'b1;  vecs[0].exp_words = 5'd5;
      vecs[0].eaddr  = {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 44'h0};
      vecs[0].edata  = {8'h79, 8'h30, 8'h7A, 8'h10, 8'h40, 88'h0};
      vecs[1]        = vecs[0];
      vecs[1].frame  = {8'h40, 8'h79, 8'h30, 8'h7A, 8'h10, 8'h40, 8'h4E, 104'h0};
      vecs[1].exp_done = 1'b0;
      vecs[2].nbytes = 8'd4;
      vecs[2].frame  = {8'h1F, 8'h07, 8'h0A, 8'hD0, 128'h0};
      vecs[2].keep   = 1'b0;  vecs[2].exp_done = 1'b1;  vecs[2].exp_words = 5'd2;
      vecs[2].eaddr  = {4'hF, 4'h0, 56'h0};
      vecs[2].edata  = {8'h07, 8'h0A, 112'h0};
      vecs[3]        = vecs[0];
      vecs[3].keep   = 1'b1;
      vecs[4].nbytes = 8'd3;
      vecs[4].frame  = {8'h03, 8'hAA, 8'h53, 136'h0};
      vecs[4].keep   = 1'b1;  vecs[4].exp_done = 1'b1;  vecs[4].exp_words = 5'd1;
      vecs[4].eaddr  = {4'h3, 60'h0};
      vecs[4].edata  = {8'hAA, 120'h0};
      // Header F8: 16 words from base 8; data 0..15 sums to 0x78, F8+78=0x70, checksum 0x90.
      vecs[5].nbytes = 8'd18;
      vecs[5].frame[0]  = 8'hF8;
      for (int k = 0; k < 16; k++) begin
         vecs[5].frame[5'(k + 1)] = 8'(k);
         vecs[5].eaddr[4'(k)]     = 4'(8 + k);
         vecs[5].edata[4'(k)]     = 8'(k);
      end
      vecs[5].frame[17] = 8'h90;
      vecs[5].keep   = 1'b0;  vecs[5].exp_done = 1'b1;  vecs[5].exp_words = 5'd16;

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rst_ready", 32'(byte_ready), 32'h0);
      chk("rst_mode", 32'(input_mode), 32'h0);
      chk("rst_addr_data", 32'({input_address, input_program}), 32'h0);
      chk("rst_cpu_reset_n", 32'(cpu_reset_n), 32'h0);
      chk("rst_flags", 32'({busy, done, error}), 32'h0);
      chk("rst_words", 32'(words_loaded), 32'h0);
      @(posedge clk);
      #1;
      chk("idle_ready", 32'(byte_ready), 32'h0);

      // start and byte_valid together in IDLE: only start acts.
      start      = 1'b1;
      byte_valid = 1'b1;
      byte_data  = 8'h40;
      @(posedge clk);
      #1;
      start      = 1'b0;
      byte_valid = 1'b0;
      chk("same_cycle_header", 32'({busy, byte_ready}), 32'h3);
      run_frame(4, 1'b0);

      for (int i = 0; i < 6; i++) run_frame(i, 1'b1);

      // start while busy (HEADER, then WRITE) is ignored; start in RUN restarts.
      pulse_start();
      pulse_start();
      chk("hdr_start_ignored", 32'({busy, byte_ready}), 32'h3);
      base = log_cnt;
      send_byte(8'h40, 1'b0);
      send_byte(8'h79, 1'b0);
      pulse_start();
      tail = '{8'h30, 8'h7A, 8'h10, 8'h40, 8'h4D};
      for (int k = 0; k < 5; k++) send_byte(tail[k], 1'b0);
      chk("busy_start_result", 32'({done, error, cpu_reset_n}), 32'h5);
      chk("busy_start_words", 32'(words_loaded), 32'h5);
      chk("busy_start_writes", 32'(log_cnt - base), 32'h5);
      pulse_start();
      chk("run_restart_flags", 32'({cpu_reset_n, done, busy, byte_ready}), 32'h3);
      chk("run_restart_words", 32'(words_loaded), 32'h0);
      run_frame(4, 1'b0);

      // Reset during the third data byte.
      pulse_start();
      base = log_cnt;
      send_byte(8'h40, 1'b0);
      send_byte(8'h79, 1'b0);
      send_byte(8'h30, 1'b0);
      byte_data  = 8'h7A;
      byte_valid = 1'b1;
      for (int k = 0; k < 64 && !byte_ready; k++) @(negedge clk);
      chk("mid_ready_before_reset", 32'(byte_ready), 32'h1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      byte_valid = 1'b0;
      chk("mid_reset_outputs",
          32'({byte_ready, input_mode, input_address, input_program, cpu_reset_n, busy, done, error}),
          32'h0);
      chk("mid_reset_words", 32'(words_loaded), 32'h0);
      chk("mid_reset_writes", 32'(log_cnt - base), 32'h2);
      chk("mid_reset_write0", 32'({log_addr[8'(base)], log_data[8'(base)]}), 32'h079);
      chk("mid_reset_write1", 32'({log_addr[8'(base + 1)], log_data[8'(base + 1)]}), 32'h130);
      reset = 1'b0;
      @(posedge clk);
      #1;
      run_frame(0, 1'b1);

      // Protocol invariants over the whole run.
      chk("write_hold_len", 32'(bad_run), 32'h0);
      chk("write_stable", 32'(unstable), 32'h0);
      chk("ready_during_write", 32'(rdy_viol), 32'h0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule : tb_program_loader
